dual_rail_fetch_bridge: RTL and testbench
=========================================

DUAL_RAIL_FETCH_BRIDGE -- requirements
Module: dual_rail_fetch_bridge

Interface
REQ-001 SHALL have parameter W, default 32: data width in bits, 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries, power of two, 2..16.
REQ-003 SHALL have parameter INIT_CYCLES, default 0: clk cycles after reset release before the first fetch request.
REQ-004 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: 1 permits new fetch cycles; 0 stops starting new ones.
REQ-007 SHALL have port i_0r, output, 1: request to the passive dual-rail source.
REQ-008 SHALL have ports i_0a0d and i_0a1d, input, W each: dual-rail acknowledge data from the source.
REQ-009 SHALL have ports o_0r0d and o_0r1d, output, W each: dual-rail request data to the passive sink.
REQ-010 SHALL have port o_0a, input, 1: acknowledge from the sink.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1: current buffer occupancy.
REQ-012 SHALL have port err, output, 1: sticky protocol-error flag.

Function
REQ-013 SHALL define "complete" as every bit satisfying (i_0a0d|i_0a1d)=1, and "null" as i_0a0d=0 and i_0a1d=0.
REQ-014 SHALL run a fetch FSM with states F_IDLE, F_REQ and F_RTZ, with i_0r registered and 1 only in F_REQ.
REQ-015 SHALL go from F_IDLE to F_REQ when enable=1, the init counter has reached 0, the input is null and count<DEPTH.
REQ-016 SHALL, in F_REQ with the input complete, write i_0a1d into the buffer tail and go to F_RTZ at that edge, so i_0r falls one cycle after complete is sampled.
REQ-017 SHALL go from F_RTZ to F_IDLE once the input is null.
REQ-018 SHALL keep the fetch FSM in F_IDLE while the buffer is full (count=DEPTH), with no request issued.
REQ-019 SHALL run a push FSM with states P_IDLE, P_DATA and P_NULL.
REQ-020 SHALL, in P_IDLE with count>0, pop the head word d at the edge, drive o_0r1d=d and o_0r0d=~d from the next cycle, and enter P_DATA.
REQ-021 SHALL go from P_DATA to P_NULL on o_0a=1, driving both rails to 0 from the next cycle.
REQ-022 SHALL go from P_NULL to P_IDLE on o_0a=0.
REQ-023 SHALL, when buffer empty, hold P_IDLE with outputs null.
REQ-024 SHALL leave count unchanged on a simultaneous write and pop in one cycle.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH.
REQ-026 SHALL preserve word order: FIFO semantics, no loss and no duplication.
REQ-027 SHALL let a dropped enable finish the current fetch cycle; the push side keeps draining.
REQ-028 SHALL give a minimum end-to-end latency of 2 cycles from complete sampled to first sink codeword visible, with the buffer empty and P_IDLE.

Reset
REQ-029 SHALL, while reset=1, set i_0r=0, o_0r0d=0, o_0r1d=0, count=0 and err=0, set the FSMs to F_IDLE and P_IDLE, clear the pointers, and load the init counter with INIT_CYCLES.
REQ-030 SHALL, on reset asserted mid-transfer, abandon the transfer and discard buffered and in-flight words, with outputs at reset values on the next cycle.
REQ-031 SHALL start the init count on the first edge with reset=0.

Configuration
REQ-032 SHALL use macro DRF_PROTOCOL_CHECK_EN to control protocol checking.
REQ-033 SHALL, when DRF_PROTOCOL_CHECK_EN is defined, set err to 1 and hold it until reset on any of: any bit with i_0a0d&i_0a1d=1; input not null while in F_IDLE with i_0r=0 one cycle after F_RTZ; o_0a=1 while in P_IDLE.
REQ-034 SHALL, when DRF_PROTOCOL_CHECK_EN is defined, otherwise behave as in REQ-013..028 on any such error.
REQ-035 SHALL, when DRF_PROTOCOL_CHECK_EN is undefined, tie err to 0 and synthesize no checking logic.

Verification
REQ-036 SHALL cover single transfer: W=32, source returns 0xDEADBEEF and sink acks after 1 cycle -> o_0r1d=0xDEADBEEF and o_0r0d=0x21524110, then null, count returns to 0.
REQ-037 SHALL cover back-pressure: DEPTH=4 with sink o_0a held 0, source supplies 1,2,3,4,5 -> count=4 and i_0r stays 0; on releasing the sink, 1..5 are delivered in order.
REQ-038 SHALL cover the init delay: INIT_CYCLES=10 -> i_0r rises on the 11th edge after reset falls, not earlier.
REQ-039 SHALL cover simultaneous push and pop: with count=2, a write and a pop in the same cycle -> count stays 2, and the pointers wrap correctly over 20 words.
REQ-040 SHALL cover reset mid-operation: assert reset during P_DATA with count=3 -> next cycle i_0r=0, outputs null and count=0; the first word after reset is fresh source data.
REQ-041 SHALL cover the protocol check: with DRF_PROTOCOL_CHECK_EN, drive bit 5 with both rails=1 -> err=1 and it stays 1 until reset; without the macro, err=0 for the same stimulus.

Source files
------------

// File: rtl/dual_rail_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dual_rail_fetch_bridge
// Description : Fetches dual-rail words from a passive source into a FIFO and
//               pushes them to a passive dual-rail sink (4-phase, RTZ).
//               Optional protocol checker: DRF_PROTOCOL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_rail_fetch_bridge #(
  parameter int W           = 32,
  parameter int DEPTH       = 4,
  parameter int INIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   i_0r,
  input  logic [W-1:0]           i_0a0d,
  input  logic [W-1:0]           i_0a1d,
  output logic [W-1:0]           o_0r0d,
  output logic [W-1:0]           o_0r1d,
  input  logic                   o_0a,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic [IW-1:0] c_init  = IW'(INIT_CYCLES);

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_REQ  = 2'd1;
  localparam logic [1:0] F_RTZ  = 2'd2;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_DATA = 2'd1;
  localparam logic [1:0] P_NULL = 2'd2;

  logic          w_in_null;
  logic          w_in_complete;
  logic          w_wr;
  logic          w_rd;
  logic [W-1:0]  w_head;

  logic [1:0]    f_state_q, f_state_d;
  logic [1:0]    p_state_q, p_state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] init_q, init_d;
  logic          i_0r_q, i_0r_d;
  logic [W-1:0]  out1_q, out1_d;
  logic [W-1:0]  out0_q, out0_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  assign w_in_null     = ~|(i_0a0d | i_0a1d);
  assign w_in_complete = &(i_0a0d | i_0a1d);
  assign w_wr          = (f_state_q == F_REQ) && w_in_complete;
  assign w_rd          = (p_state_q == P_IDLE) && (count_q != '0);
  assign w_head        = mem_q[rd_ptr_q];

  // State register: both FSMs, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      f_state_q <= F_IDLE;
      p_state_q <= P_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      init_q    <= c_init;
      i_0r_q    <= 1'b0;
      out1_q    <= '0;
      out0_q    <= '0;
    end else begin
      f_state_q <= f_state_d;
      p_state_q <= p_state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      init_q    <= init_d;
      i_0r_q    <= i_0r_d;
      out1_q    <= out1_d;
      out0_q    <= out0_d;
    end
  end

  // Storage is not reset; occupancy and pointers define what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Next-state logic
  always_comb begin
    f_state_d = f_state_q;
    case (f_state_q)
      F_IDLE: if (enable && (init_q == '0) && w_in_null && (count_q < c_depth))
                f_state_d = F_REQ;
      F_REQ:  if (w_in_complete) f_state_d = F_RTZ;
      F_RTZ:  if (w_in_null) f_state_d = F_IDLE;
      default: f_state_d = F_IDLE;
    endcase

    p_state_d = p_state_q;
    case (p_state_q)
      P_IDLE: if (count_q != '0) p_state_d = P_DATA;
      P_DATA: if (o_0a) p_state_d = P_NULL;
      P_NULL: if (!o_0a) p_state_d = P_IDLE;
      default: p_state_d = P_IDLE;
    endcase
  end

  // FIFO datapath and init countdown
  always_comb begin
    mem_d = mem_q;
    if (w_wr) mem_d[wr_ptr_q] = i_0a1d;

    wr_ptr_d = w_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({w_wr, w_rd})
      2'b10:   count_d = count_q + c_one;
      2'b01:   count_d = count_q - c_one;
      default: count_d = count_q;
    endcase

    init_d = (init_q != '0) ? init_q - 1'b1 : init_q;
  end

  // Output logic: request and sink rails are registered from next state
  always_comb begin
    i_0r_d = (f_state_d == F_REQ);
    if (w_rd) begin
      out1_d = w_head;
      out0_d = ~w_head;
    end else if (p_state_d == P_DATA) begin
      out1_d = out1_q;
      out0_d = out0_q;
    end else begin
      out1_d = '0;
      out0_d = '0;
    end
  end

  assign i_0r   = i_0r_q;
  assign o_0r1d = out1_q;
  assign o_0r0d = out0_q;
  assign count  = count_q;

`ifdef DRF_PROTOCOL_CHECK_EN
  logic err_q, err_d;
  logic after_rtz_q, after_rtz_d;

  // A source must stay null in the first idle cycle after return-to-zero
  always_comb begin
    after_rtz_d = (f_state_q == F_RTZ) && (f_state_d == F_IDLE);
    err_d = err_q
          | (|(i_0a0d & i_0a1d))
          | (after_rtz_q && (f_state_q == F_IDLE) && !i_0r_q && !w_in_null)
          | ((p_state_q == P_IDLE) && o_0a);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q       <= 1'b0;
      after_rtz_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      after_rtz_q <= after_rtz_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_rail_fetch_bridge
// Description : Randomised source/sink handshakes against a transaction-level
//               model of dual_rail_fetch_bridge, plus directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_rail_fetch_bridge;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int INIT  = 10;
`ifdef DRF_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   enable = 1'b0;
  logic                   i_0r;
  logic [W-1:0]           a0 = '0;
  logic [W-1:0]           a1 = '0;
  logic [W-1:0]           o0;
  logic [W-1:0]           o1;
  logic                   o_0a = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   err;

  always #5 clk = ~clk;

  dual_rail_fetch_bridge #(.W(W), .DEPTH(DEPTH), .INIT_CYCLES(INIT)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .i_0r   (i_0r),
    .i_0a0d (a0),
    .i_0a1d (a1),
    .o_0r0d (o0),
    .o_0r1d (o1),
    .o_0a   (o_0a),
    .count  (count),
    .err    (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Bench controls
  logic         src_rand = 1'b0;
  logic         sink_hold = 1'b0;
  logic         ovr = 1'b0;
  logic [W-1:0] ovr_val = '0;
  logic         err_chk_en = 1'b1;
  int           dly_max = 2;
  logic [W-1:0] dirq[$];

  // Source and sink behaviour, acting 2 time units after each rising edge
  int           s_st = 0, s_dly = 0, k_st = 0, k_dly = 0;
  logic [W-1:0] s_word = '0;
  initial forever begin
    @(posedge clk);
    #2;
    if (reset) begin
      s_st = 0; k_st = 0; a0 = '0; a1 = '0; o_0a = 1'b0;
    end else begin
      if (ovr) begin
        a0 = ovr_val; a1 = ovr_val;
      end else begin
        case (s_st)
          0: if (i_0r && (src_rand || dirq.size() > 0)) begin
               s_word = (dirq.size() > 0) ? dirq.pop_front() : W'($urandom);
               s_dly = $urandom_range(0, dly_max);
               s_st = 1;
             end
          1: if (s_dly == 0) begin a1 = s_word; a0 = ~s_word; s_st = 2; end
             else s_dly--;
          2: if (!i_0r) begin s_dly = $urandom_range(0, dly_max); s_st = 3; end
          default: if (s_dly == 0) begin a1 = '0; a0 = '0; s_st = 0; end
                   else s_dly--;
        endcase
      end
      case (k_st)
        0: if (((o0 | o1) != '0) && !sink_hold) begin
             k_dly = $urandom_range(0, dly_max); k_st = 1;
           end
        1: if (k_dly == 0) begin o_0a = 1'b1; k_st = 2; end
           else k_dly--;
        2: if ((o0 | o1) == '0) begin k_dly = $urandom_range(0, dly_max); k_st = 3; end
        default: if (k_dly == 0) begin o_0a = 1'b0; k_st = 0; end
                 else k_dly--;
      endcase
    end
  end

  // Transaction model: fetch phase, FIFO queue, sink word, checked every cycle
  int           m_phase = 0;  // 0 waiting, 1 requesting, 2 returning to zero
  int           m_cnt = 0;
  int           m_since = 0;
  logic [W-1:0] m_q[$];
  logic         m_valid = 1'b0;
  logic         m_ready = 1'b1;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] got[$];
  int           cyc = 0, wr_cyc = 0, pop_cyc = 0;

  initial forever begin
    int cnt_pre;
    bit wr, pp, in_nul, in_cmp;
    logic [W-1:0] e1, e0;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      m_phase = 0; m_cnt = 0; m_since = 0; m_q.delete();
      m_valid = 1'b0; m_ready = 1'b1; m_word = '0;
    end else begin
      in_nul = ((a0 | a1) == '0);
      in_cmp = (&(a0 | a1));
      cnt_pre = m_cnt; wr = 0; pp = 0;
      case (m_phase)
        0: if (enable && m_since >= INIT && in_nul && cnt_pre < DEPTH) m_phase = 1;
        1: if (in_cmp) begin wr = 1; m_phase = 2; end
        default: if (in_nul) m_phase = 0;
      endcase
      if (m_since < INIT) m_since++;
      if (m_valid) begin
        if (o_0a) m_valid = 1'b0;
      end else if (m_ready) begin
        if (cnt_pre > 0) begin
          pp = 1; m_word = m_q.pop_front(); m_valid = 1'b1; m_ready = 1'b0;
        end
      end else if (!o_0a) begin
        m_ready = 1'b1;
      end
      if (wr) begin m_q.push_back(a1); wr_cyc = cyc; end
      if (pp) begin got.push_back(m_word); pop_cyc = cyc; end
      m_cnt = cnt_pre + int'(wr) - int'(pp);
    end
    e1 = m_valid ? m_word : '0;
    e0 = m_valid ? ~m_word : '0;
    chk("i_0r", i_0r, (m_phase == 1));
    chk("count", count, m_cnt);
    chk("o_0r1d", o1, e1);
    chk("o_0r0d", o0, e0);
    if (err_chk_en) chk("err", err, 1'b0);
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step();
    chk("reset_count", count, 0);
    chk("reset_i_0r", i_0r, 0);
    chk("reset_rails", {o1, o0}, 0);
    chk("reset_err", err, 0);

    // Init delay and a single transfer
    dirq.push_back(32'hDEADBEEF);
    enable = 1'b1;
    reset = 1'b0;
    n = 0;
    while (!i_0r && n < 40) begin step(); n++; end
    chk("init_delay_edges", n, INIT + 1);
    n = 0;
    while ((o0 | o1) == '0 && n < 100) begin step(); n++; end
    chk("single_timeout", n < 100, 1);
    chk("single_o_0r1d", o1, 32'hDEADBEEF);
    chk("single_o_0r0d", o0, 32'h21524110);
    chk("single_latency", pop_cyc - wr_cyc, 1);
    n = 0;
    while (((o0 | o1) != '0 || count != 0) && n < 100) begin step(); n++; end
    chk("single_drain", n < 100, 1);

    // Back-pressure: sink stalled, five words offered
    got.delete();
    sink_hold = 1'b1;
    for (int v = 1; v <= 5; v++) dirq.push_back(W'(v));
    n = 0;
    while (count != 4 && n < 200) begin step(); n++; end
    chk("bp_fill_timeout", n < 200, 1);
    repeat (10) step();
    chk("bp_count_full", count, 4);
    chk("bp_no_request", i_0r, 0);
    chk("bp_head_on_rails", o1, 1);
    sink_hold = 1'b0;
    n = 0;
    while ((got.size() < 5 || count != 0) && n < 300) begin step(); n++; end
    chk("bp_drain_timeout", n < 300, 1);
    for (int i = 0; i < 5; i++) chk("bp_order", (got.size() > i) ? got[i] : '0, W'(i + 1));

    // Random traffic: many words through the ring
    got.delete();
    src_rand = 1'b1;
    repeat (600) step();
    src_rand = 1'b0;
    n = 0;
    while ((count != 0 || (o0 | o1) != '0 || s_st != 0) && n < 300) begin step(); n++; end
    chk("rand_drain_timeout", n < 300, 1);
    chk("rand_wrap_words", got.size() >= 20, 1);

    // Reset while the sink is stalled with three words buffered
    sink_hold = 1'b1;
    src_rand = 1'b1;
    n = 0;
    while (count != 3 && n < 200) begin step(); n++; end
    chk("rst_fill_timeout", n < 200, 1);
    src_rand = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_i_0r", i_0r, 0);
    chk("rst_rails", {o1, o0}, 0);
    chk("rst_count", count, 0);
    step();
    got.delete();
    dirq.delete();
    dirq.push_back(32'hA5A5A5A5);
    sink_hold = 1'b0;
    reset = 1'b0;
    n = 0;
    while (!i_0r && n < 50) begin step(); n++; end
    chk("rst_rereq_timeout", n < 50, 1);
    enable = 1'b0;
    n = 0;
    while ((got.size() < 1 || count != 0 || (o0 | o1) != '0) && n < 100) begin step(); n++; end
    chk("rst_fresh_word", (got.size() > 0) ? got[0] : '0, 32'hA5A5A5A5);
    repeat (30) step();
    chk("enable_drop_no_req", i_0r, 0);
    chk("enable_drop_words", got.size(), 1);

    // Protocol violation: bit 5 driven on both rails
    err_chk_en = 1'b0;
    ovr_val = 32'h0000_0020;
    ovr = 1'b1;
    repeat (3) step();
    chk("err_set", err, EXP_ERR);
    ovr_val = '0;
    repeat (5) step();
    chk("err_sticky", err, EXP_ERR);
    chk("err_count_idle", count, 0);
    reset = 1'b1;
    repeat (2) step();
    chk("err_cleared", err, 0);
    ovr = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    err_chk_en = 1'b1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
